// File: rtl/l1d_mshr_ctrl_if.sv
// rtl/l1d_mshr_ctrl_if.sv - miss, lower-cache request, fill and status signals of the L1D MSHR controller
//
// Purpose : bundles every handshake/bus signal of l1d_mshr_ctrl so the
//           controller and its environment connect through one port.
// Ports   : miss_*  - miss request from the L1D lookup (valid/ready, address,
//                     assigned entry index, secondary-miss flag)
//           lc_*    - line fetch request to the lower cache (valid/ready, address)
//           fill_*  - fill return from the lower cache (valid/ready, address)
//           free_*  - one-cycle pulse naming the entry a fill retired
//           full_out, err_out - status (no free entry, sticky unmatched fill)
// Modports: slave  - the MSHR controller
//           master - the L1D / lower cache side driving it
interface l1d_mshr_ctrl_if #(
  parameter int PADDR_BITS = 22,
  parameter int IDX_W      = 2
);
  logic                  miss_valid_in;
  logic                  miss_ready_out;
  logic [PADDR_BITS-1:0] miss_paddr_in;
  logic [IDX_W-1:0]      miss_idx_out;
  logic                  miss_merged_out;

  logic                  lc_valid_out;
  logic                  lc_ready_in;
  logic [PADDR_BITS-1:0] lc_addr_out;

  logic                  fill_valid_in;
  logic                  fill_ready_out;
  logic [PADDR_BITS-1:0] fill_addr_in;

  logic                  free_valid_out;
  logic [IDX_W-1:0]      free_idx_out;
  logic                  full_out;
  logic                  err_out;

  modport slave (
    input  miss_valid_in, miss_paddr_in, lc_ready_in, fill_valid_in, fill_addr_in,
    output miss_ready_out, miss_idx_out, miss_merged_out, lc_valid_out, lc_addr_out,
           fill_ready_out, free_valid_out, free_idx_out, full_out, err_out
  );

  modport master (
    output miss_valid_in, miss_paddr_in, lc_ready_in, fill_valid_in, fill_addr_in,
    input  miss_ready_out, miss_idx_out, miss_merged_out, lc_valid_out, lc_addr_out,
           fill_ready_out, free_valid_out, free_idx_out, full_out, err_out
  );
endinterface

// File: rtl/l1d_mshr_ctrl.sv
// rtl/l1d_mshr_ctrl.sv - L1D miss status holding register controller
//
// Purpose : tracks up to MSHR_COUNT outstanding line misses. Each entry is
//           FREE, PENDING (allocated, not yet requested) or ISSUED (request
//           accepted by the lower cache). New misses either allocate the
//           lowest FREE entry or, with merging enabled, attach to the entry
//           already tracking the same line. Fills retire ISSUED entries.
// Ports   : clk_in   - clock, all state changes on the rising edge
//           rst_N_in - asynchronous active-low reset
//           bus      - l1d_mshr_ctrl_if.slave (miss, lc, fill, free, status)
// Macro   : MSHR_MERGE_EN - when defined, a miss to a line already tracked is
//           accepted as a secondary miss; when undefined such a miss stalls
//           until the tracking entry is freed and miss_merged_out is 0.
module l1d_mshr_ctrl #(
  parameter int MSHR_COUNT = 4,
  parameter int PADDR_BITS = 22,
  parameter int B          = 64
) (
  input  logic             clk_in,
  input  logic             rst_N_in,
  l1d_mshr_ctrl_if.slave   bus
);
  localparam int OFF   = $clog2(B);
  localparam int IDX_W = $clog2(MSHR_COUNT);
  localparam int LW    = PADDR_BITS - OFF;

  typedef enum logic [1:0] {E_FREE, E_PENDING, E_ISSUED} ent_state_t;

  ent_state_t          st_q   [MSHR_COUNT];
  ent_state_t          st_d   [MSHR_COUNT];
  logic [LW-1:0]       line_q [MSHR_COUNT];
  logic [LW-1:0]       line_d [MSHR_COUNT];

  logic                  lc_valid_q, lc_valid_d;
  logic [PADDR_BITS-1:0] lc_addr_q,  lc_addr_d;
  logic [IDX_W-1:0]      lc_idx_q,   lc_idx_d;
  logic                  free_valid_q, free_valid_d;
  logic [IDX_W-1:0]      free_idx_q,   free_idx_d;
  logic                  err_q, err_d;

  logic [LW-1:0]         miss_line, fill_line;
  logic [MSHR_COUNT-1:0] hit_vec, free_vec, fill_vec, pend_vec, issue_vec;
  logic [IDX_W-1:0]      hit_idx, alloc_idx, fill_idx, issue_idx;
  logic                  hit_any, free_any, fill_hit, issue_any, same_line;
  logic                  miss_ready, miss_fire, fill_fire, lc_fire;

  // Offset bits never take part in line matching.
  logic unused_offsets;
  assign unused_offsets = ^{bus.miss_paddr_in[OFF-1:0], bus.fill_addr_in[OFF-1:0]};

  function automatic logic [IDX_W-1:0] lowest(input logic [MSHR_COUNT-1:0] vec);
    lowest = '0;
    for (int i = MSHR_COUNT - 1; i >= 0; i--) begin
      if (vec[i]) lowest = IDX_W'(i);
    end
  endfunction

  assign miss_line = bus.miss_paddr_in[PADDR_BITS-1:OFF];
  assign fill_line = bus.fill_addr_in[PADDR_BITS-1:OFF];

  // All lookups use registered state only, so an entry freed this cycle
  // cannot be reallocated until the next one.
  always_comb begin
    hit_vec  = '0;
    free_vec = '0;
    fill_vec = '0;
    pend_vec = '0;
    for (int i = 0; i < MSHR_COUNT; i++) begin
      hit_vec[i]  = (st_q[i] != E_FREE) && (line_q[i] == miss_line);
      free_vec[i] = (st_q[i] == E_FREE);
      fill_vec[i] = (st_q[i] == E_ISSUED) && (line_q[i] == fill_line);
      pend_vec[i] = (st_q[i] == E_PENDING);
    end
  end

  // The entry currently on the lc port is still PENDING; exclude it so a
  // transfer can immediately chain to the next pending entry.
  assign issue_vec = lc_valid_q ? (pend_vec & ~(MSHR_COUNT'(1) << lc_idx_q)) : pend_vec;

  assign hit_any   = |hit_vec;
  assign free_any  = |free_vec;
  assign fill_hit  = |fill_vec;
  assign issue_any = |issue_vec;
  assign hit_idx   = lowest(hit_vec);
  assign alloc_idx = lowest(free_vec);
  assign fill_idx  = lowest(fill_vec);
  assign issue_idx = lowest(issue_vec);

  // A fill to the same line takes priority; the miss retries next cycle and
  // then sees the entry already freed.
  assign same_line = bus.fill_valid_in && (fill_line == miss_line);

`ifdef MSHR_MERGE_EN
  assign miss_ready          = !same_line && (hit_any || free_any);
  assign bus.miss_merged_out = hit_any;
`else
  assign miss_ready          = !same_line && !hit_any && free_any;
  assign bus.miss_merged_out = 1'b0;
`endif

  assign miss_fire = bus.miss_valid_in && miss_ready;
  assign fill_fire = bus.fill_valid_in;
  assign lc_fire   = lc_valid_q && bus.lc_ready_in;

  // Allocation touches a FREE entry, the fill an ISSUED one and the issue a
  // PENDING one, so the three updates never collide on the same entry.
  always_comb begin
    st_d         = st_q;
    line_d       = line_q;
    lc_valid_d   = lc_valid_q;
    lc_addr_d    = lc_addr_q;
    lc_idx_d     = lc_idx_q;
    free_valid_d = 1'b0;
    free_idx_d   = free_idx_q;
    err_d        = err_q;

    if (miss_fire && !hit_any) begin
      st_d[alloc_idx]   = E_PENDING;
      line_d[alloc_idx] = miss_line;
    end

    if (fill_fire && fill_hit) begin
      st_d[fill_idx] = E_FREE;
      free_valid_d   = 1'b1;
      free_idx_d     = fill_idx;
    end else if (fill_fire) begin
      err_d = 1'b1;
    end

    if (lc_fire) st_d[lc_idx_q] = E_ISSUED;

    if (!lc_valid_q || lc_fire) begin
      if (issue_any) begin
        lc_valid_d = 1'b1;
        lc_addr_d  = {line_q[issue_idx], {OFF{1'b0}}};
        lc_idx_d   = issue_idx;
      end else begin
        lc_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < MSHR_COUNT; i++) begin
        st_q[i]   <= E_FREE;
        line_q[i] <= '0;
      end
      lc_valid_q   <= 1'b0;
      lc_addr_q    <= '0;
      lc_idx_q     <= '0;
      free_valid_q <= 1'b0;
      free_idx_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < MSHR_COUNT; i++) begin
        st_q[i]   <= st_d[i];
        line_q[i] <= line_d[i];
      end
      lc_valid_q   <= lc_valid_d;
      lc_addr_q    <= lc_addr_d;
      lc_idx_q     <= lc_idx_d;
      free_valid_q <= free_valid_d;
      free_idx_q   <= free_idx_d;
      err_q        <= err_d;
    end
  end

  assign bus.miss_ready_out = miss_ready;
  assign bus.miss_idx_out   = hit_any ? hit_idx : alloc_idx;
  assign bus.lc_valid_out   = lc_valid_q;
  assign bus.lc_addr_out    = lc_addr_q;
  assign bus.fill_ready_out = 1'b1;
  assign bus.free_valid_out = free_valid_q;
  assign bus.free_idx_out   = free_idx_q;
  assign bus.full_out       = !free_any;
  assign bus.err_out        = err_q;
endmodule

// File: tb/tb_l1d_mshr_ctrl.sv
// tb/tb_l1d_mshr_ctrl.sv - directed table-driven bench for l1d_mshr_ctrl
module tb_l1d_mshr_ctrl;
  logic clk_in = 1'b0;
  logic rst_N_in;
  always #5 clk_in = ~clk_in;

  l1d_mshr_ctrl_if #(.PADDR_BITS(22), .IDX_W(2)) bus_if ();

  l1d_mshr_ctrl #(.MSHR_COUNT(4), .PADDR_BITS(22), .B(64)) dut (
    .clk_in   (clk_in),
    .rst_N_in (rst_N_in),
    .bus      (bus_if.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic        mv;
    logic [21:0] pa;
    logic        lr;
    logic        fv;
    logic [21:0] fa;
    logic        e_mr;
    logic [1:0]  e_idx;
    logic        e_mg;
    logic        e_lv;
    logic [21:0] e_la;
    logic        e_fv;
    logic [1:0]  e_fi;
    logic        e_full;
    logic        e_err;
  } vec_t;

  vec_t vt [24];

  function automatic vec_t v(input logic mv, input logic [21:0] pa, input logic lr,
                             input logic fv, input logic [21:0] fa,
                             input logic e_mr, input logic [1:0] e_idx, input logic e_mg,
                             input logic e_lv, input logic [21:0] e_la,
                             input logic e_fv, input logic [1:0] e_fi,
                             input logic e_full, input logic e_err);
    vec_t r;
    r.mv = mv; r.pa = pa; r.lr = lr; r.fv = fv; r.fa = fa;
    r.e_mr = e_mr; r.e_idx = e_idx; r.e_mg = e_mg; r.e_lv = e_lv; r.e_la = e_la;
    r.e_fv = e_fv; r.e_fi = e_fi; r.e_full = e_full; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mv, input logic [21:0] pa, input logic lr,
                       input logic fv, input logic [21:0] fa);
    bus_if.miss_valid_in = mv;
    bus_if.miss_paddr_in = pa;
    bus_if.lc_ready_in   = lr;
    bus_if.fill_valid_in = fv;
    bus_if.fill_addr_in  = fa;
  endtask

  task automatic next_cycle;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0);
    rst_N_in = 1'b0;
    next_cycle();
    rst_N_in = 1'b1;
  endtask

  int ntx;

  initial begin
    vt[0]  = v(0, 22'h00000, 0, 0, 22'h00000, 1, 0, 0, 0, 22'h00000, 0, 0, 0, 0);
    vt[1]  = v(1, 22'h01040, 0, 0, 22'h00000, 1, 0, 0, 0, 22'h00000, 0, 0, 0, 0);
    vt[2]  = v(0, 22'h00000, 0, 0, 22'h00000, 1, 0, 0, 0, 22'h00000, 0, 0, 0, 0);
    vt[3]  = v(1, 22'h02000, 0, 0, 22'h00000, 1, 1, 0, 1, 22'h01040, 0, 0, 0, 0);
    vt[4]  = v(1, 22'h03000, 0, 0, 22'h00000, 1, 2, 0, 1, 22'h01040, 0, 0, 0, 0);
    vt[5]  = v(1, 22'h04000, 0, 0, 22'h00000, 1, 3, 0, 1, 22'h01040, 0, 0, 0, 0);
    vt[6]  = v(1, 22'h05000, 0, 0, 22'h00000, 0, 0, 0, 1, 22'h01040, 0, 0, 1, 0);
    vt[7]  = v(1, 22'h05000, 1, 0, 22'h00000, 0, 0, 0, 1, 22'h01040, 0, 0, 1, 0);
    vt[8]  = v(1, 22'h05000, 1, 0, 22'h00000, 0, 0, 0, 1, 22'h02000, 0, 0, 1, 0);
    vt[9]  = v(1, 22'h05000, 1, 0, 22'h00000, 0, 0, 0, 1, 22'h03000, 0, 0, 1, 0);
    vt[10] = v(1, 22'h05000, 1, 0, 22'h00000, 0, 0, 0, 1, 22'h04000, 0, 0, 1, 0);
    vt[11] = v(1, 22'h05000, 0, 1, 22'h03000, 0, 0, 0, 0, 22'h00000, 0, 0, 1, 0);
    vt[12] = v(1, 22'h05000, 0, 0, 22'h00000, 1, 2, 0, 0, 22'h00000, 1, 2, 0, 0);
    vt[13] = v(0, 22'h00000, 0, 0, 22'h00000, 0, 0, 0, 0, 22'h00000, 0, 0, 1, 0);
    vt[14] = v(0, 22'h00000, 1, 0, 22'h00000, 0, 0, 0, 1, 22'h05000, 0, 0, 1, 0);
    vt[15] = v(0, 22'h00000, 0, 1, 22'h3FFC0, 0, 0, 0, 0, 22'h00000, 0, 0, 1, 0);
    vt[16] = v(0, 22'h00000, 0, 0, 22'h00000, 0, 0, 0, 0, 22'h00000, 0, 0, 1, 1);
    vt[17] = v(0, 22'h00000, 0, 1, 22'h01040, 0, 0, 0, 0, 22'h00000, 0, 0, 1, 1);
    vt[18] = v(0, 22'h00000, 0, 0, 22'h00000, 1, 0, 0, 0, 22'h00000, 1, 0, 0, 1);
    vt[19] = v(0, 22'h00000, 0, 0, 22'h00000, 1, 0, 0, 0, 22'h00000, 0, 0, 0, 1);
    vt[20] = v(1, 22'h02000, 0, 1, 22'h02000, 0, 0, 0, 0, 22'h00000, 0, 0, 0, 1);
    vt[21] = v(1, 22'h02000, 0, 0, 22'h00000, 1, 0, 0, 0, 22'h00000, 1, 1, 0, 1);
    vt[22] = v(0, 22'h00000, 0, 0, 22'h00000, 1, 0, 0, 0, 22'h00000, 0, 0, 0, 1);
    vt[23] = v(0, 22'h00000, 0, 0, 22'h00000, 1, 0, 0, 1, 22'h02000, 0, 0, 0, 1);

    drive(0, 0, 0, 0, 0);
    rst_N_in = 1'b0;
    #3;
    chk("rst_miss_ready", 32'(bus_if.miss_ready_out), 1);
    chk("rst_full", 32'(bus_if.full_out), 0);
    chk("rst_fill_ready", 32'(bus_if.fill_ready_out), 1);
    chk("rst_lc_valid", 32'(bus_if.lc_valid_out), 0);
    chk("rst_err", 32'(bus_if.err_out), 0);
    next_cycle();
    rst_N_in = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].mv, vt[i].pa, vt[i].lr, vt[i].fv, vt[i].fa);
      @(negedge clk_in);
      chk($sformatf("v%0d_miss_ready", i), 32'(bus_if.miss_ready_out), 32'(vt[i].e_mr));
      if (vt[i].mv && vt[i].e_mr) begin
        chk($sformatf("v%0d_miss_idx", i), 32'(bus_if.miss_idx_out), 32'(vt[i].e_idx));
        chk($sformatf("v%0d_merged", i), 32'(bus_if.miss_merged_out), 32'(vt[i].e_mg));
      end
      chk($sformatf("v%0d_lc_valid", i), 32'(bus_if.lc_valid_out), 32'(vt[i].e_lv));
      if (vt[i].e_lv)
        chk($sformatf("v%0d_lc_addr", i), 32'(bus_if.lc_addr_out), 32'(vt[i].e_la));
      chk($sformatf("v%0d_free_valid", i), 32'(bus_if.free_valid_out), 32'(vt[i].e_fv));
      if (vt[i].e_fv)
        chk($sformatf("v%0d_free_idx", i), 32'(bus_if.free_idx_out), 32'(vt[i].e_fi));
      chk($sformatf("v%0d_full", i), 32'(bus_if.full_out), 32'(vt[i].e_full));
      chk($sformatf("v%0d_err", i), 32'(bus_if.err_out), 32'(vt[i].e_err));
      chk($sformatf("v%0d_fill_ready", i), 32'(bus_if.fill_ready_out), 1);
      next_cycle();
    end

    // Secondary miss to a line already tracked.
    do_reset();
    drive(1, 22'h01040, 0, 0, 0);
    @(negedge clk_in);
    chk("sec_first_ready", 32'(bus_if.miss_ready_out), 1);
    chk("sec_first_idx", 32'(bus_if.miss_idx_out), 0);
    chk("sec_first_merged", 32'(bus_if.miss_merged_out), 0);
    next_cycle();
    drive(1, 22'h01078, 1, 0, 0);
    @(negedge clk_in);
`ifdef MSHR_MERGE_EN
    chk("sec_merge_ready", 32'(bus_if.miss_ready_out), 1);
    chk("sec_merge_idx", 32'(bus_if.miss_idx_out), 0);
    chk("sec_merge_merged", 32'(bus_if.miss_merged_out), 1);
    next_cycle();
    drive(0, 0, 1, 0, 0);
`else
    chk("sec_stall_ready", 32'(bus_if.miss_ready_out), 0);
    next_cycle();
`endif
    ntx = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      if (bus_if.lc_valid_out && bus_if.lc_ready_in) begin
        ntx++;
        chk("sec_lc_addr", 32'(bus_if.lc_addr_out), 32'h01040);
      end
`ifndef MSHR_MERGE_EN
      chk($sformatf("sec_stall_hold%0d", k), 32'(bus_if.miss_ready_out), 0);
`endif
      next_cycle();
    end
    chk("sec_lc_req_count", 32'(ntx), 1);
`ifdef MSHR_MERGE_EN
    drive(0, 0, 0, 1, 22'h01040);
`else
    drive(1, 22'h01078, 0, 1, 22'h01040);
    @(negedge clk_in);
    chk("sec_fill_same_line", 32'(bus_if.miss_ready_out), 0);
`endif
    next_cycle();
`ifdef MSHR_MERGE_EN
    drive(0, 0, 0, 0, 0);
`else
    drive(1, 22'h01078, 0, 0, 0);
`endif
    @(negedge clk_in);
    chk("sec_free_valid", 32'(bus_if.free_valid_out), 1);
    chk("sec_free_idx", 32'(bus_if.free_idx_out), 0);
`ifndef MSHR_MERGE_EN
    chk("sec_retry_ready", 32'(bus_if.miss_ready_out), 1);
    chk("sec_retry_idx", 32'(bus_if.miss_idx_out), 0);
    chk("sec_retry_merged", 32'(bus_if.miss_merged_out), 0);
`endif
    next_cycle();

    // Reset in the middle of three issued misses and a pending fill.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 22'h10000 + 22'(k * 'h1000), 1, 0, 0);
      @(negedge clk_in);
      chk($sformatf("mid_alloc%0d_ready", k), 32'(bus_if.miss_ready_out), 1);
      chk($sformatf("mid_alloc%0d_idx", k), 32'(bus_if.miss_idx_out), 32'(k));
      next_cycle();
    end
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) next_cycle();
    @(negedge clk_in);
    chk("mid_lc_idle", 32'(bus_if.lc_valid_out), 0);
    next_cycle();
    drive(0, 0, 1, 1, 22'h3FFC0);
    next_cycle();
    chk("mid_err_set", 32'(bus_if.err_out), 1);
    drive(0, 0, 1, 1, 22'h10000);
    #2;
    rst_N_in = 1'b0;
    #1;
    chk("mid_rst_lc_valid", 32'(bus_if.lc_valid_out), 0);
    chk("mid_rst_lc_addr", 32'(bus_if.lc_addr_out), 0);
    chk("mid_rst_free_valid", 32'(bus_if.free_valid_out), 0);
    chk("mid_rst_err", 32'(bus_if.err_out), 0);
    chk("mid_rst_full", 32'(bus_if.full_out), 0);
    chk("mid_rst_miss_ready", 32'(bus_if.miss_ready_out), 1);
    next_cycle();
    chk("mid_rst_no_pulse", 32'(bus_if.free_valid_out), 0);
    rst_N_in = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk_in);
    chk("mid_post_no_pulse", 32'(bus_if.free_valid_out), 0);
    next_cycle();
    drive(1, 22'h10000, 0, 0, 0);
    @(negedge clk_in);
    chk("mid_realloc_ready", 32'(bus_if.miss_ready_out), 1);
    chk("mid_realloc_idx", 32'(bus_if.miss_idx_out), 0);
    chk("mid_realloc_merged", 32'(bus_if.miss_merged_out), 0);
    chk("mid_post_free_valid", 32'(bus_if.free_valid_out), 0);
    next_cycle();
    drive(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
